prog_counter_seq: RTL and testbench

//   Parametrised program counter for the microprocessor fetch stage. Generalises the

---
 rtl/prog_counter_seq.sv | 177 +++++++++++++++++
 tb/tb_prog_counter_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter_seq.sv
// ---------------------------------------------------------------------------
// prog_counter_seq
//
// Program counter for the fetch stage. Each cycle it selects one action, in
// this order of priority:
//   reset (power_i low) > hold > return > call > jump > branch > step.
// The sequential step wraps from last_add_i back to RST_ADD. A small LIFO
// return stack backs call/return. Overflow and underflow set a sticky error
// flag that only reset clears.
//
// Ports
//   clk_i        system clock, all state updates on the rising edge
//   power_i      synchronous active-low reset (0 = reset)
//   hold_i       stall: address, stack and error flag stay as they are
//   last_add_i   highest program address; the sequential step wraps after it
//   jump_i       absolute jump to jump_add_i
//   jump_add_i   jump / call target
//   branch_i     relative branch by offset_i
//   offset_i     signed two's-complement branch offset
//   call_i       push the return address, then go to jump_add_i
//   ret_i        pop the return address into the program counter
//   add_o        current program address (registered)
//   wrap_o       one-cycle pulse after a sequential step last_add_i -> RST_ADD
//   stk_full_o   stack holds STK_DEPTH entries
//   stk_empty_o  stack holds no entries
//   stk_err_o    sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module prog_counter_seq #(
    parameter int unsigned AW        = 8,
    parameter int unsigned STK_DEPTH = 4,
    parameter int unsigned RST_ADD   = 0
) (
    input  logic          clk_i,
    input  logic          power_i,
    input  logic          hold_i,
    input  logic [AW-1:0] last_add_i,
    input  logic          jump_i,
    input  logic [AW-1:0] jump_add_i,
    input  logic          branch_i,
    input  logic [AW-1:0] offset_i,
    input  logic          call_i,
    input  logic          ret_i,
    output logic [AW-1:0] add_o,
    output logic          wrap_o,
    output logic          stk_full_o,
    output logic          stk_empty_o,
    output logic          stk_err_o
);

    // The count needs to reach STK_DEPTH itself, so it is one value wider
    // than the entry index.
    localparam int unsigned CW = $clog2(STK_DEPTH + 1);
    localparam int unsigned IW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    localparam logic [AW-1:0] RST_VAL = AW'(RST_ADD);
    localparam logic [AW-1:0] ADD_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STK_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0] add_q,   add_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          wrap_q,  wrap_d;
    logic          err_q,   err_d;

    // Return-stack storage. It is not reset: an entry can be read only
    // while the count covers it.
    logic [AW-1:0] stk_q [STK_DEPTH];

    // ------------------------------------------------------------------
    // Derived values
    // ------------------------------------------------------------------
    logic          at_last;
    logic [AW-1:0] seq_add;
    logic          stk_full;
    logic          stk_empty;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] pop_idx;
    logic [AW-1:0] top_entry;
    logic          push_en;

    // The step does not correct an address above last_add_i. It keeps
    // counting modulo 2^AW until it comes round to last_add_i.
    assign at_last = (add_q == last_add_i);
    assign seq_add = at_last ? RST_VAL : (add_q + ADD_ONE);

    assign stk_full  = (cnt_q == CNT_MAX);
    assign stk_empty = (cnt_q == '0);

    // Push goes to slot [count]. Pop reads slot [count-1]. Doing the pop
    // subtraction in index width gives the right slot even when the stack
    // is full, because the count then equals STK_DEPTH.
    assign push_idx  = cnt_q[IW-1:0];
    assign pop_idx   = cnt_q[IW-1:0] - IW'(1);
    assign top_entry = stk_q[pop_idx];

    // ------------------------------------------------------------------
    // Next-state selection. The first request that matches wins, and any
    // lower request in the same cycle is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        add_d   = add_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        push_en = 1'b0;

        if (hold_i) begin
            add_d = add_q;
        end else if (ret_i) begin
            if (!stk_empty) begin
                add_d = top_entry;
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                // Underflow: fall back to a plain step, and the step may wrap.
                add_d  = seq_add;
                wrap_d = at_last;
                err_d  = 1'b1;
            end
        end else if (call_i) begin
            add_d = jump_add_i;
            if (!stk_full) begin
                push_en = 1'b1;
                cnt_d   = cnt_q + CNT_ONE;
            end else begin
                // Overflow: the jump still happens, but the return address is lost.
                err_d = 1'b1;
            end
        end else if (jump_i) begin
            add_d = jump_add_i;
        end else if (branch_i) begin
            // Two's-complement add of the same width is the signed offset,
            // modulo 2^AW. last_add_i is not involved.
            add_d = add_q + offset_i;
        end else begin
            add_d  = seq_add;
            wrap_d = at_last;
        end
    end

    // ------------------------------------------------------------------
    // Registers. Reset overrides every request, including a pending call.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!power_i) begin
            add_q  <= RST_VAL;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            add_q  <= add_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    // Stack write port. The address pushed is where execution resumes,
    // which is the step address (it may already have wrapped).
    always_ff @(posedge clk_i) begin
        if (power_i && push_en) begin
            stk_q[push_idx] <= seq_add;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign add_o       = add_q;
    assign wrap_o      = wrap_q;
    assign stk_full_o  = stk_full;
    assign stk_empty_o = stk_empty;
    assign stk_err_o   = err_q;

endmodule

// File: tb/tb_prog_counter_seq.sv
module tb_prog_counter_seq;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int RST   = 0;

    logic          clk_i = 1'b0;
    logic          power_i;
    logic          hold_i;
    logic [AW-1:0] last_add_i;
    logic          jump_i;
    logic [AW-1:0] jump_add_i;
    logic          branch_i;
    logic [AW-1:0] offset_i;
    logic          call_i;
    logic          ret_i;
    logic [AW-1:0] add_o;
    logic          wrap_o;
    logic          stk_full_o;
    logic          stk_empty_o;
    logic          stk_err_o;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_add;
    int m_stk[$];
    bit m_err;
    bit m_wrap;

    prog_counter_seq #(.AW(AW), .STK_DEPTH(DEPTH), .RST_ADD(RST)) dut (
        .clk_i      (clk_i),
        .power_i    (power_i),
        .hold_i     (hold_i),
        .last_add_i (last_add_i),
        .jump_i     (jump_i),
        .jump_add_i (jump_add_i),
        .branch_i   (branch_i),
        .offset_i   (offset_i),
        .call_i     (call_i),
        .ret_i      (ret_i),
        .add_o      (add_o),
        .wrap_o     (wrap_o),
        .stk_full_o (stk_full_o),
        .stk_empty_o(stk_empty_o),
        .stk_err_o  (stk_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int seqf(int x);
        return (x == int'(last_add_i)) ? RST : (x + 1) % 256;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_req();
        hold_i = 0; jump_i = 0; branch_i = 0; call_i = 0; ret_i = 0;
    endtask

    // Advance the model from the current requests, clock the DUT, and
    // compare every output 1 time unit after the edge.
    task automatic tick();
        if (!power_i) begin
            m_add = RST; m_stk.delete(); m_err = 0; m_wrap = 0;
        end else if (hold_i) begin
            m_wrap = 0;
        end else if (ret_i) begin
            if (m_stk.size() > 0) begin
                m_add = m_stk.pop_back(); m_wrap = 0;
            end else begin
                m_wrap = (m_add == int'(last_add_i));
                m_add  = seqf(m_add);
                m_err  = 1;
            end
        end else if (call_i) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(seqf(m_add));
            else m_err = 1;
            m_add = int'(jump_add_i); m_wrap = 0;
        end else if (jump_i) begin
            m_add = int'(jump_add_i); m_wrap = 0;
        end else if (branch_i) begin
            m_add = (m_add + int'(offset_i)) % 256; m_wrap = 0;
        end else begin
            m_wrap = (m_add == int'(last_add_i));
            m_add  = seqf(m_add);
        end
        @(posedge clk_i);
        #1;
        chk("add",   32'(add_o),       32'(m_add));
        chk("wrap",  32'(wrap_o),      32'(m_wrap));
        chk("full",  32'(stk_full_o),  32'(m_stk.size() == DEPTH));
        chk("empty", 32'(stk_empty_o), 32'(m_stk.size() == 0));
        chk("err",   32'(stk_err_o),   32'(m_err));
    endtask

    task automatic do_reset();
        clr_req();
        power_i = 0;
        tick();
        power_i = 1;
    endtask

    task automatic do_call(int tgt);
        clr_req(); call_i = 1; jump_add_i = AW'(tgt); tick(); clr_req();
    endtask

    task automatic do_jump(int tgt);
        clr_req(); jump_i = 1; jump_add_i = AW'(tgt); tick(); clr_req();
    endtask

    task automatic do_ret();
        clr_req(); ret_i = 1; tick(); clr_req();
    endtask

    initial begin
        clr_req();
        power_i = 0; last_add_i = 8'h0F; jump_add_i = 0; offset_i = 0;
        @(posedge clk_i); #1;
        do_reset();
        chk("rst_add", 32'(add_o), 32'h00);
        chk("rst_empty", 32'(stk_empty_o), 32'd1);

        // 1: count 01..0F then wrap to 00
        for (int i = 0; i < 16; i++) tick();
        chk("t1_add", 32'(add_o), 32'h00);
        chk("t1_wrap", 32'(wrap_o), 32'd1);
        tick();
        chk("t1_wrap_off", 32'(wrap_o), 32'd0);

        // 2: reset with two stack entries at add 07
        do_reset();
        do_call(8'h05);
        do_call(8'h06);
        tick();
        chk("t2_pre", 32'(add_o), 32'h07);
        power_i = 0; call_i = 1; jump_add_i = 8'h99;
        tick();
        power_i = 1; clr_req();
        chk("t2_add", 32'(add_o), 32'h00);
        chk("t2_empty", 32'(stk_empty_o), 32'd1);
        chk("t2_err", 32'(stk_err_o), 32'd0);
        last_add_i = 8'h1F;
        for (int i = 0; i < 31; i++) tick();
        chk("t2_1f", 32'(add_o), 32'h1F);
        tick();
        chk("t2_wrap", 32'(wrap_o), 32'd1);

        // 3: branches, jump, hold
        last_add_i = 8'hFF;
        do_jump(8'h05);
        branch_i = 1; offset_i = 8'hFD; tick(); clr_req();
        chk("t3_br_neg", 32'(add_o), 32'h02);
        do_jump(8'hFE);
        branch_i = 1; offset_i = 8'h04; tick(); clr_req();
        chk("t3_br_wrap", 32'(add_o), 32'h02);
        do_jump(8'h40);
        chk("t3_jump", 32'(add_o), 32'h40);
        hold_i = 1; jump_i = 1; jump_add_i = 8'h77; tick(); clr_req();
        chk("t3_hold", 32'(add_o), 32'h40);

        // 4: call/return
        do_jump(8'h10);
        do_call(8'h30);
        chk("t4_call", 32'(add_o), 32'h30);
        do_ret();
        chk("t4_ret", 32'(add_o), 32'h11);
        last_add_i = 8'h10;
        do_jump(8'h10);
        do_call(8'h30);
        do_ret();
        chk("t4_ret_wrap", 32'(add_o), 32'h00);
        do_call(8'h30);
        call_i = 1; ret_i = 1; jump_add_i = 8'h50; tick(); clr_req();
        chk("t4_ret_wins", 32'(add_o), 32'h01);
        chk("t4_empty", 32'(stk_empty_o), 32'd1);

        // 5: overflow and underflow
        last_add_i = 8'hFF;
        do_reset();
        do_call(8'h20); do_call(8'h30); do_call(8'h40); do_call(8'h50);
        chk("t5_full", 32'(stk_full_o), 32'd1);
        chk("t5_noerr", 32'(stk_err_o), 32'd0);
        do_call(8'h60);
        chk("t5_ovf_add", 32'(add_o), 32'h60);
        chk("t5_ovf_err", 32'(stk_err_o), 32'd1);
        do_ret(); chk("t5_pop1", 32'(add_o), 32'h41);
        do_ret(); chk("t5_pop2", 32'(add_o), 32'h31);
        do_ret(); chk("t5_pop3", 32'(add_o), 32'h21);
        do_ret(); chk("t5_pop4", 32'(add_o), 32'h01);
        do_ret(); chk("t5_unf", 32'(add_o), 32'h02);
        chk("t5_empty", 32'(stk_empty_o), 32'd1);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            power_i    = ($urandom_range(0, 49) != 0);
            hold_i     = ($urandom_range(0, 9) == 0);
            ret_i      = ($urandom_range(0, 5) == 0);
            call_i     = ($urandom_range(0, 5) == 0);
            jump_i     = ($urandom_range(0, 7) == 0);
            branch_i   = ($urandom_range(0, 7) == 0);
            jump_add_i = AW'($urandom_range(0, 255));
            offset_i   = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) last_add_i = AW'($urandom_range(0, 40));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
